game_controller: RTL and testbench
==================================

# game_controller

Sequencing controller for the 4x4 tile-merge game datapath. It owns the game FSM, a spawn LFSR and a line counter. It drives the next-state matrix into the existing free-running matrix register and reads the current matrix back from it. It sits between the debounced direction-button logic and the board register/display path, and it applies one direction move per accepted command, spawns tiles and detects win/lose.

## Interface
Parameters:
- WIN_VALUE, 12'd2048, tile value that ends the game as won
- LFSR_SEED, 16'hACE1, non-zero reset value of the spawn LFSR

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  synchronous new-game request, honoured in any state
- dir_valid  in  1  direction command valid
- dir  in  2  00 up, 01 down, 10 left, 11 right
- dir_ready  out  1  high only in S_WAIT; a command is accepted when dir_valid && dir_ready
- matrix_Q  in  12 x [3:0][3:0]  current board from the matrix register, indexed [row][col]
- matrix_D  out  12 x [3:0][3:0]  next board to the matrix register; combinational
- state  out  3  FSM code, for the display
- score  out  20  running score, wraps modulo 2^20
- won, lost  out  1  registered game-over flags

## Operation
- Encoding: S_CLEAR=0, S_SPAWN=1, S_CHECK=2, S_WAIT=3, S_MOVE=4, S_WIN=5, S_LOSE=6.
- matrix_D equals matrix_Q in every state except S_CLEAR, S_SPAWN (write cycle) and S_MOVE. The downstream register has no enable.
- S_CLEAR:
  - matrix_D is all zero; score is cleared and won/lost are cleared.
  - spawn_cnt is set to 2. Next state is S_SPAWN.
- S_SPAWN:
  - The candidate index p (4-bit, row = p[3:2], col = p[1:0]) is loaded from lfsr[3:0] on entry.
  - If cell p is non-zero, p is incremented mod 16 and the FSM stays in S_SPAWN.
  - If cell p is zero, that cell is written in matrix_D with 4 when lfsr[7:4]==0, otherwise with 2. spawn_cnt is then decremented.
  - After the write: if spawn_cnt is still non-zero, stay in S_SPAWN and reload p. Otherwise go to S_CHECK.
  - Spawning is entered only when an empty cell exists, so the search ends within 16 cycles.
- S_CHECK:
  - If any tile equals WIN_VALUE, go to S_WIN.
  - Otherwise, if no tile is zero and no horizontally or vertically adjacent pair is equal, go to S_LOSE.
  - Otherwise go to S_WAIT.
- S_WAIT: dir_ready=1. On accept, dir is latched, line=0, changed=0, and the FSM goes to S_MOVE.
- S_MOVE: one line is processed per cycle, with line = 0..3.
  - left: row `line`, read col 0 to 3. right: row `line`, read col 3 to 0.
  - up: column `line`, read row 0 to 3. down: column `line`, read row 3 to 0.
  - Merge rule, in the read order: compact non-zero tiles, merge each equal adjacent pair once (a result never merges again in the same move), compact again, zero-fill the tail. The output is written back in the same order.
  - score is increased by the sum of the merged values. changed |= (output != input).
  - After line 3: if changed, spawn_cnt=1 and go to S_SPAWN; otherwise go to S_WAIT (a no-op move spawns nothing).
- S_WIN sets won=1. S_LOSE sets lost=1. Both states hold until start.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, so spawn positions depend on player timing.
- start has priority over every transition and goes to S_CLEAR next cycle, including mid-S_MOVE and mid-S_SPAWN. A partially moved board is discarded.

## Timing
- Reset value of every output:
  - state=S_CLEAR, dir_ready=0, score=0, won=0, lost=0.
  - matrix_D is all zero while in S_CLEAR, so the board is cleared on the first clk edge after rst deasserts.
- Command accepted at edge N. Lines 0..3 load into the register at edges N+1..N+4. S_SPAWN or S_WAIT is entered at N+4.
- Spawn: 1 + k cycles per tile, where k is the number of occupied cells skipped. S_CHECK takes 1 cycle.
- S_CHECK evaluates matrix_Q, which already holds the spawned tile.
- dir_valid outside S_WAIT is ignored, not queued.

## Structure
- game_pkg:
  - state_t enum, dir codes, tile_t = logic[11:0]
  - LFSR tap constant, default WIN_VALUE
  - board_t type for the [3:0][3:0] tile array
- Sub-module line_merge: combinational, 4 tile_t in, 4 tile_t out, plus a 13-bit merge sum and a changed flag.
  - game_controller instantiates one line_merge and muxes the selected line into and out of it.
- The FSM, LFSR, spawn search and win/lose check live in game_controller.

## Test plan
The bench models the matrix register (matrix_Q <= matrix_D) and can override it to inject boards.
- Reset release -> board all zero for 1 cycle, then exactly two non-zero tiles (each 2 or 4), then state=S_WAIT and dir_ready=1.
- Row 0 [2,2,2,2] + left -> [4,4,0,0], score +8, one new tile spawned, back in S_WAIT.
- Row 0 [2,2,4,0] + left -> [4,4,0,0] (no chained 8). Same row + right -> [0,0,4,4]. Column 0 [2,0,2,0] + down -> [0,0,0,4].
- Board where left changes nothing -> 4 S_MOVE cycles, back in S_WAIT at N+4, tile count unchanged, score unchanged.
- Row 0 [1024,1024,0,0] + left -> cell (0,0)=2048, S_WIN, won=1, dir_ready stays 0 until start.
- Full board checkerboard of 2/4 after spawn -> S_LOSE, lost=1.
- start asserted during line 2 of S_MOVE -> S_CLEAR next cycle, score=0, board zeroed.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the 4x4 tile-merge game controller.
//   tile_t  : one 12-bit tile value (0 = empty cell)
//   line_t  : four tiles of one row/column, element 0 first in read order
//   board_t : whole board, indexed [row][col]
//   state_t : controller FSM encoding (also shown on the display)
package game_pkg;

  typedef logic [11:0] tile_t;
  typedef tile_t [3:0] line_t;
  typedef tile_t [3:0][3:0] board_t;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_SPAWN = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_MOVE  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam tile_t       WIN_VALUE_DEFAULT = 12'd2048;

  localparam tile_t TILE_2 = 12'd2;
  localparam tile_t TILE_4 = 12'd4;

  // One LFSR step: shift towards the MSB, feedback enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/line_merge.sv
// line_merge: combinational slide-and-merge of one 4-tile line.
//   line_i    : tiles in read order (element 0 is the edge tiles slide towards)
//   line_o    : merged line, written back in the same order, zero-filled tail
//   sum_o     : sum of all values produced by merges in this line
//   changed_o : line_o differs from line_i
module line_merge
  import game_pkg::*;
(
  input  line_t       line_i,
  output line_t       line_o,
  output logic [12:0] sum_o,
  output logic        changed_o
);

  line_t      packed_l;
  logic [2:0] n;
  logic [3:0] eq;
  logic [2:0] m;
  logic       skip;
  logic [12:0] dbl;

  // First compaction: non-zero tiles moved to the front, order kept.
  always_comb begin
    packed_l = '0;
    n        = '0;
    for (int i = 0; i < 4; i++) begin
      if (line_i[i] != '0) begin
        packed_l[n[1:0]] = line_i[i];
        n = n + 3'd1;
      end
    end
  end

  // eq[i]: compacted tiles i and i+1 form a mergeable pair.
  for (genvar gi = 0; gi < 3; gi++) begin : g_eq
    assign eq[gi] = (packed_l[gi] != '0) && (packed_l[gi] == packed_l[gi+1]);
  end
  assign eq[3] = 1'b0;

  // Merge pass: a merged result is skipped past, so it never merges again.
  // Emitting into a separate output index performs the second compaction.
  always_comb begin
    line_o = '0;
    sum_o  = '0;
    m      = '0;
    skip   = 1'b0;
    dbl    = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (eq[i]) begin
        dbl              = {1'b0, packed_l[i]} << 1;
        line_o[m[1:0]]   = dbl[11:0];
        sum_o            = sum_o + dbl;
        m                = m + 3'd1;
        skip             = 1'b1;
      end else if (packed_l[i] != '0) begin
        line_o[m[1:0]] = packed_l[i];
        m              = m + 3'd1;
      end
    end
  end

  assign changed_o = (line_o != line_i);

endmodule

// File: rtl/game_controller.sv
// game_controller: sequencing controller for the 4x4 tile-merge game.
//   clk, rst           : clock, asynchronous active-low reset
//   start              : new-game request, overrides every transition
//   dir_valid/dir      : direction command (00 up, 01 down, 10 left, 11 right)
//   dir_ready          : high only while waiting for a command
//   matrix_Q           : current board from the external matrix register
//   matrix_D           : next board into that register (combinational)
//   state              : FSM code for the display
//   score              : running score, wraps modulo 2^20
//   won, lost          : registered game-over flags
module game_controller
  import game_pkg::*;
#(
  parameter tile_t       WIN_VALUE = WIN_VALUE_DEFAULT,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir_valid,
  input  logic [1:0]  dir,
  output logic        dir_ready,
  input  board_t      matrix_Q,
  output board_t      matrix_D,
  output logic [2:0]  state,
  output logic [19:0] score,
  output logic        won,
  output logic        lost
);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic        changed_q, changed_d;
  logic [1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [3:0]  p_q, p_d;
  logic        p_valid_q, p_valid_d;
  logic [19:0] score_q, score_d;
  logic        won_q, won_d;
  logic        lost_q, lost_d;

  // ---------------------------------------------------------------------------
  // Line selection: element k of the active line lives at (row_idx[k], col_idx[k]).
  // Reverse directions read from the far edge, which is ~k for a 2-bit index.
  // ---------------------------------------------------------------------------
  logic [3:0][1:0] row_idx;
  logic [3:0][1:0] col_idx;
  line_t           line_in;
  line_t           line_out;
  logic [12:0]     merge_sum;
  logic            merge_changed;

  for (genvar gi = 0; gi < 4; gi++) begin : g_map
    localparam logic [1:0] K = 2'(gi);
    assign row_idx[gi] = (dir_q == DIR_UP)   ? K  :
                         (dir_q == DIR_DOWN) ? ~K : line_q;
    assign col_idx[gi] = (dir_q == DIR_LEFT)  ? K  :
                         (dir_q == DIR_RIGHT) ? ~K : line_q;
    assign line_in[gi] = matrix_Q[row_idx[gi]][col_idx[gi]];
  end

  line_merge u_line_merge (
    .line_i    (line_in),
    .line_o    (line_out),
    .sum_o     (merge_sum),
    .changed_o (merge_changed)
  );

  // ---------------------------------------------------------------------------
  // Board status for the win/lose decision.
  // ---------------------------------------------------------------------------
  logic any_win, any_zero, any_pair;

  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (matrix_Q[r][c] == WIN_VALUE) any_win  = 1'b1;
        if (matrix_Q[r][c] == '0)        any_zero = 1'b1;
      end
    end
    // Horizontal pairs in row r, and vertical pairs in column r.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (matrix_Q[r][c] == matrix_Q[r][c+1]) any_pair = 1'b1;
        if (matrix_Q[c][r] == matrix_Q[c+1][r]) any_pair = 1'b1;
      end
    end
  end

  // Spawn candidate: a fresh LFSR sample on the first cycle of each search.
  logic [3:0] cur_p;
  assign cur_p = p_valid_q ? p_q : lfsr_q[3:0];

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_step(lfsr_q);
    dir_d       = dir_q;
    line_d      = line_q;
    changed_d   = changed_q;
    spawn_cnt_d = spawn_cnt_q;
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    score_d     = score_q;
    won_d       = won_q;
    lost_d      = lost_q;
    matrix_D    = matrix_Q;   // register has no enable: default is hold
    dir_ready   = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        matrix_D    = '0;
        score_d     = '0;
        won_d       = 1'b0;
        lost_d      = 1'b0;
        spawn_cnt_d = 2'd2;
        p_valid_d   = 1'b0;
        state_d     = S_SPAWN;
      end

      S_SPAWN: begin
        if (matrix_Q[cur_p[3:2]][cur_p[1:0]] != '0) begin
          p_d       = cur_p + 4'd1;
          p_valid_d = 1'b1;
        end else begin
          matrix_D[cur_p[3:2]][cur_p[1:0]] = (lfsr_q[7:4] == 4'd0) ? TILE_4 : TILE_2;
          spawn_cnt_d = spawn_cnt_q - 2'd1;
          p_valid_d   = 1'b0;   // next tile searches from a new LFSR sample
          if (spawn_cnt_q == 2'd1) state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (any_win) begin
          state_d = S_WIN;
          won_d   = 1'b1;
        end else if (!any_zero && !any_pair) begin
          state_d = S_LOSE;
          lost_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        dir_ready = 1'b1;
        if (dir_valid) begin
          dir_d     = dir;
          line_d    = 2'd0;
          changed_d = 1'b0;
          state_d   = S_MOVE;
        end
      end

      S_MOVE: begin
        for (int k = 0; k < 4; k++) begin
          matrix_D[row_idx[k]][col_idx[k]] = line_out[k];
        end
        score_d   = score_q + {7'd0, merge_sum};
        changed_d = changed_q | merge_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (changed_q | merge_changed) begin
            spawn_cnt_d = 2'd1;
            p_valid_d   = 1'b0;
            state_d     = S_SPAWN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WIN, S_LOSE: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // New game wins over everything; a half-moved board is thrown away.
    if (start) begin
      state_d = S_CLEAR;
      score_d = '0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      lfsr_q      <= LFSR_SEED;
      dir_q       <= DIR_UP;
      line_q      <= '0;
      changed_q   <= 1'b0;
      spawn_cnt_q <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      score_q     <= '0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      changed_q   <= changed_d;
      spawn_cnt_q <= spawn_cnt_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      score_q     <= score_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
    end
  end

  assign state = state_q;
  assign score = score_q;
  assign won   = won_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;
  import game_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir_valid;
  logic [1:0]  dir;
  logic        dir_ready;
  board_t      matrix_Q;
  board_t      matrix_D;
  logic [2:0]  state;
  logic [19:0] score;
  logic        won;
  logic        lost;

  // Model of the free-running matrix register, with a board-injection override.
  logic   inj_en;
  board_t inj_board;

  always @(posedge clk) matrix_Q <= inj_en ? inj_board : matrix_D;

  game_controller #(
    .WIN_VALUE (12'd2048),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir_valid (dir_valid),
    .dir       (dir),
    .dir_ready (dir_ready),
    .matrix_Q  (matrix_Q),
    .matrix_D  (matrix_D),
    .state     (state),
    .score     (score),
    .won       (won),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    board_t      board;
    logic [19:0] score;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  logic [19:0] exp_score;

  // Reference move: per line, gather non-zero tiles in read order, then pop
  // from the front, fusing the head with the next tile when they are equal.
  function automatic void model_move(input board_t b, input logic [1:0] d,
                                     output board_t o, output int sum);
    int q[$];
    int res[$];
    int r, c, a;
    o   = '0;
    sum = 0;
    for (int l = 0; l < 4; l++) begin
      q   = {};
      res = {};
      for (int k = 0; k < 4; k++) begin
        case (d)
          DIR_UP:   begin r = k;     c = l;     end
          DIR_DOWN: begin r = 3 - k; c = l;     end
          DIR_LEFT: begin r = l;     c = k;     end
          default:  begin r = l;     c = 3 - k; end
        endcase
        if (b[r][c] != 0) q.push_back(int'(b[r][c]));
      end
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a) begin
          void'(q.pop_front());
          res.push_back(2 * a);
          sum += 2 * a;
        end else begin
          res.push_back(a);
        end
      end
      for (int k = 0; k < 4; k++) begin
        case (d)
          DIR_UP:   begin r = k;     c = l;     end
          DIR_DOWN: begin r = 3 - k; c = l;     end
          DIR_LEFT: begin r = l;     c = k;     end
          default:  begin r = l;     c = 3 - k; end
        endcase
        o[r][c] = (k < res.size()) ? 12'(res[k]) : 12'd0;
      end
    end
  endfunction

  function automatic int tiles(input board_t b);
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0) n++;
    return n;
  endfunction

  function automatic logic only_2_or_4(input board_t b);
    logic ok = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 0 && b[r][c] != 2 && b[r][c] != 4) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, state, target);
  endtask

  // Called on a negedge in S_WAIT: inject board b and issue direction d in the
  // same cycle, then compare the moved board against the scoreboard entry.
  task automatic do_move(input string tag, input board_t b, input logic [1:0] d);
    board_t eb;
    int     s;
    int     cyc;
    exp_t   e;
    model_move(b, d, eb, s);
    e.board = eb;
    e.score = exp_score + 20'(s);
    e.st    = (eb != b) ? S_SPAWN : S_WAIT;
    sb_q.push_back(e);

    inj_board = b;
    inj_en    = 1'b1;
    dir       = d;
    dir_valid = 1'b1;
    @(negedge clk);
    inj_en    = 1'b0;
    dir_valid = 1'b0;
    check({tag, "_accept"}, state, S_MOVE);

    cyc = 0;
    while (state == S_MOVE && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_move_cycles"}, cyc, 4);

    e = sb_q.pop_front();
    check({tag, "_board"}, matrix_Q, e.board);
    check({tag, "_score"}, score, e.score);
    check({tag, "_state_after"}, state, e.st);
    exp_score = e.score;
    $display("move %s dir=%0d score=%0d next_state=%0d", tag, d, score, state);

    if (e.st == S_SPAWN) begin
      wait_state(S_CHECK, 40, {tag, "_spawn"});
      check({tag, "_spawn_count"}, tiles(matrix_Q), tiles(e.board) + 1);
    end
  endtask

  board_t b;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    dir_valid = 1'b0;
    dir       = 2'b00;
    inj_en    = 1'b0;
    inj_board = '0;
    exp_score = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", state, S_CLEAR);
    check("rst_dir_ready", dir_ready, 1'b0);
    check("rst_score", score, 20'd0);
    check("rst_won", won, 1'b0);
    check("rst_lost", lost, 1'b0);
    check("rst_matrix_D", matrix_D, 192'd0);

    rst = 1'b1;
    @(negedge clk);
    check("boot_board_zero", matrix_Q, 192'd0);
    check("boot_spawn_state", state, S_SPAWN);
    wait_state(S_WAIT, 60, "boot");
    check("boot_tiles", tiles(matrix_Q), 2);
    check("boot_values", only_2_or_4(matrix_Q), 1'b1);
    check("boot_dir_ready", dir_ready, 1'b1);
    $display("boot done state=%0d tiles=%0d", state, tiles(matrix_Q));

    // Row 0 [2,2,2,2] left (rows written col3..col0)
    b = '0; b[0] = {12'd2, 12'd2, 12'd2, 12'd2};
    do_move("row2222_left", b, DIR_LEFT);
    wait_state(S_WAIT, 40, "row2222_left");

    // Row 0 [2,2,4,0] left, then right
    b = '0; b[0] = {12'd0, 12'd4, 12'd2, 12'd2};
    do_move("row2240_left", b, DIR_LEFT);
    wait_state(S_WAIT, 40, "row2240_left");
    do_move("row2240_right", b, DIR_RIGHT);
    wait_state(S_WAIT, 40, "row2240_right");

    // Column 0 [2,0,2,0] down
    b = '0; b[0][0] = 12'd2; b[2][0] = 12'd2;
    do_move("col2020_down", b, DIR_DOWN);
    wait_state(S_WAIT, 40, "col2020_down");

    // No-op left: rows already packed, no equal neighbours
    b = '0; b[0] = {12'd0, 12'd8, 12'd4, 12'd2}; b[1] = {12'd0, 12'd0, 12'd8, 12'd4};
    do_move("noop_left", b, DIR_LEFT);
    check("noop_tiles", tiles(matrix_Q), 5);
    check("noop_dir_ready", dir_ready, 1'b1);

    // start during line 2 of a move
    b = '0; b[0] = {12'd0, 12'd0, 12'd2, 12'd2}; b[2] = {12'd4, 12'd4, 12'd0, 12'd0};
    inj_board = b; inj_en = 1'b1; dir = DIR_LEFT; dir_valid = 1'b1;
    @(negedge clk);
    inj_en = 1'b0; dir_valid = 1'b0;
    check("mid_accept", state, S_MOVE);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_clear_state", state, S_CLEAR);
    @(negedge clk);
    check("mid_board_zero", matrix_Q, 192'd0);
    check("mid_score_zero", score, 20'd0);
    exp_score = '0;
    $display("start mid-move state=%0d score=%0d", state, score);
    wait_state(S_WAIT, 60, "mid_restart");

    // Lose: left leaves a single hole at (3,3) surrounded by 8 and 16
    b[0] = {12'd4, 12'd2, 12'd4, 12'd2};
    b[1] = {12'd2, 12'd4, 12'd2, 12'd4};
    b[2] = {12'd16, 12'd2, 12'd4, 12'd2};
    b[3] = {12'd8, 12'd2, 12'd4, 12'd0};
    do_move("lose_left", b, DIR_LEFT);
    wait_state(S_LOSE, 10, "lose");
    @(negedge clk);
    check("lose_flag", lost, 1'b1);
    check("lose_won_low", won, 1'b0);
    $display("lose state=%0d lost=%0d", state, lost);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = '0;
    wait_state(S_WAIT, 60, "lose_restart");
    check("lose_restart_lost", lost, 1'b0);

    // Win: [1024,1024,0,0] left
    b = '0; b[0] = {12'd0, 12'd0, 12'd1024, 12'd1024};
    do_move("win_left", b, DIR_LEFT);
    wait_state(S_WIN, 10, "win");
    check("win_cell", matrix_Q[0][0], 12'd2048);
    @(negedge clk);
    check("win_flag", won, 1'b1);
    dir_valid = 1'b1;
    dir       = DIR_RIGHT;
    for (int i = 0; i < 4; i++) begin
      check("win_dir_ready", dir_ready, 1'b0);
      check("win_hold", state, S_WIN);
      @(negedge clk);
    end
    dir_valid = 1'b0;
    $display("win state=%0d won=%0d score=%0d", state, won, score);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("win_start_state", state, S_CLEAR);
    @(negedge clk);
    check("win_start_won", won, 1'b0);
    check("win_start_board", matrix_Q, 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
